// File: rtl/shifter_pkg.sv
// Shared constants and the per-stage control word for the pipelined barrel shifter.
// Optional status outputs (out_zero, out_carry) are built when SHIFTER_STATUS_EN is defined.
package shifter_pkg;

  localparam logic [1:0] MODE_LOG = 2'd0;
  localparam logic [1:0] MODE_ARI = 2'd1;
  localparam logic [1:0] MODE_ROT = 2'd2;
  localparam logic [1:0] MODE_RSV = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Shift field is sized for WIDTH up to 256; unused upper bits stay zero.
  localparam int SHIFT_MAX_W = 8;

  typedef struct packed {
    logic [SHIFT_MAX_W-1:0] shift;
    logic                   dir;
    logic [1:0]             mode;
    logic                   sign;
    logic                   err;
    logic                   carry;
  } stage_ctrl_t;

endpackage

// File: rtl/shifter_stage.sv
// One log-shifter stage: conditional 2^STAGE shift/rotate plus a valid/ready register slot.
// With SHIFTER_STATUS_EN defined it also tracks the last shifted-out bit and a zero flag.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  stage_ctrl_t      in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output stage_ctrl_t      out_ctrl
`ifdef SHIFTER_STATUS_EN
  ,
  output logic             out_zero
`endif
);

  localparam int AMT = 1 << STAGE;

  logic [WIDTH-1:0] shifted;
  stage_ctrl_t      next_ctrl;
  logic             take;

  // Reserved-mode ops arrive with zeroed data; skipping them keeps carry at 0.
  assign take = in_ctrl.shift[STAGE] && !in_ctrl.err;

  // NOTE: defaults come first so every path assigns every output (no latch).
  always_comb begin
    shifted   = in_data;
    next_ctrl = in_ctrl;
    if (take) begin
      if (in_ctrl.dir == DIR_LEFT) begin
        if (in_ctrl.mode == MODE_ROT)
          shifted = {in_data[WIDTH-AMT-1:0], in_data[WIDTH-1:WIDTH-AMT]};
        else
          shifted = {in_data[WIDTH-AMT-1:0], {AMT{1'b0}}};
`ifdef SHIFTER_STATUS_EN
        next_ctrl.carry = in_data[WIDTH-AMT];
`endif
      end else begin
        if (in_ctrl.mode == MODE_ROT)
          shifted = {in_data[AMT-1:0], in_data[WIDTH-1:AMT]};
        else if (in_ctrl.mode == MODE_ARI)
          shifted = {{AMT{in_ctrl.sign}}, in_data[WIDTH-1:AMT]};
        else
          shifted = {{AMT{1'b0}}, in_data[WIDTH-1:AMT]};
`ifdef SHIFTER_STATUS_EN
        next_ctrl.carry = in_data[AMT-1];
`endif
      end
    end
  end

  // Slot can load when empty or when its occupant leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  // NOTE: non-blocking assignments so every stage samples pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well, so out_data reads 0 straight out of reset.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
`ifdef SHIFTER_STATUS_EN
      out_zero  <= 1'b0;
`endif
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= shifted;
        out_ctrl <= next_ctrl;
`ifdef SHIFTER_STATUS_EN
        out_zero <= (shifted == '0);
`endif
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter: SHW registered log stages with bubble-collapsing valid/ready.
// SHIFTER_STATUS_EN adds registered out_zero and out_carry outputs.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
`ifdef SHIFTER_STATUS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  logic [SHW-1:0]   s_valid;
  logic [SHW-1:0]   s_ready;
  logic [WIDTH-1:0] s_data [SHW];
  stage_ctrl_t      s_ctrl [SHW];
`ifdef SHIFTER_STATUS_EN
  logic [SHW-1:0]   s_zero;
`endif

  logic [WIDTH-1:0] head_data;
  stage_ctrl_t      head_ctrl;
  logic             rsv;

  // Reserved ops enter as zero data so every stage naturally yields out_data = 0.
  assign rsv       = (in_mode == MODE_RSV);
  assign head_data = rsv ? '0 : in_data;

  always_comb begin
    head_ctrl       = '0;
    head_ctrl.shift = SHIFT_MAX_W'(in_shift);
    head_ctrl.dir   = in_dir;
    head_ctrl.mode  = in_mode;
    head_ctrl.sign  = in_data[WIDTH-1];
    head_ctrl.err   = rsv;
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    stage_ctrl_t      up_ctrl;
    logic             dn_ready;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = head_data;
      assign up_ctrl  = head_ctrl;
    end else begin : g_body
      assign up_valid = s_valid[k-1];
      assign up_data  = s_data[k-1];
      assign up_ctrl  = s_ctrl[k-1];
    end

    if (k == SHW - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = s_ready[k+1];
    end

    shifter_stage #(
      .WIDTH (WIDTH),
      .STAGE (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (up_valid),
      .in_ready  (s_ready[k]),
      .in_data   (up_data),
      .in_ctrl   (up_ctrl),
      .out_valid (s_valid[k]),
      .out_ready (dn_ready),
      .out_data  (s_data[k]),
      .out_ctrl  (s_ctrl[k])
`ifdef SHIFTER_STATUS_EN
      ,
      .out_zero  (s_zero[k])
`endif
    );
  end

  assign in_ready  = s_ready[0];
  assign out_valid = s_valid[SHW-1];
  assign out_data  = s_data[SHW-1];
  assign out_err   = s_ctrl[SHW-1].err;

  // Control fields that are fully consumed before the output are folded here.
  logic unused_ctrl;
`ifdef SHIFTER_STATUS_EN
  assign out_zero    = s_zero[SHW-1];
  assign out_carry   = s_ctrl[SHW-1].carry;
  assign unused_ctrl = ^{s_ctrl[SHW-1].shift, s_ctrl[SHW-1].dir, s_ctrl[SHW-1].mode,
                         s_ctrl[SHW-1].sign, s_zero[SHW-2:0]};
`else
  assign unused_ctrl = ^{s_ctrl[SHW-1].shift, s_ctrl[SHW-1].dir, s_ctrl[SHW-1].mode,
                         s_ctrl[SHW-1].sign, s_ctrl[SHW-1].carry};
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at WIDTH = 8 (three stages).
// Status outputs are checked too when SHIFTER_STATUS_EN is defined.
module tb_pipelined_barrel_shifter;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [SHW-1:0]   in_shift = '0;
  logic             in_dir = 1'b0;
  logic [1:0]       in_mode = 2'd0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
`ifdef SHIFTER_STATUS_EN
  logic             out_zero;
  logic             out_carry;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] exp_d;
    logic       exp_err;
    logic       exp_c;
  } op_t;

  op_t ops [16];

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef SHIFTER_STATUS_EN
    ,
    .out_zero  (out_zero),
    .out_carry (out_carry)
`endif
  );

  // Bit-by-bit reference: returns {carry, data}.
  function automatic logic [8:0] model(input logic [7:0] d, input int s, input logic dir,
                                       input logic [1:0] mode);
    logic [7:0] r;
    logic       c;
    int         src;
    r = '0;
    c = 1'b0;
    if (mode == 2'd3) return 9'h000;
    for (int i = 0; i < 8; i++) begin
      if (dir == 1'b0) begin
        src = i - s;
        if (mode == 2'd2) r[i] = d[(src + 8) % 8];
        else if (src >= 0) r[i] = d[src];
        else r[i] = 1'b0;
      end else begin
        src = i + s;
        if (mode == 2'd2) r[i] = d[src % 8];
        else if (src < 8) r[i] = d[src];
        else r[i] = (mode == 2'd1) ? d[7] : 1'b0;
      end
    end
    if (s != 0) begin
      if (mode == 2'd2) c = dir ? r[7] : r[0];
      else c = dir ? d[s-1] : d[8-s];
    end
    return {c, r};
  endfunction

  task automatic run_op(input string name, input logic [7:0] d, input logic [2:0] s,
                        input logic dir, input logic [1:0] mode, input logic [7:0] exp_d,
                        input logic exp_err, input logic exp_c);
    int lat;
    @(negedge clk);
    in_data   = d;
    in_shift  = s;
    in_dir    = dir;
    in_mode   = mode;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h5A;
    in_mode  = 2'd2;
    in_shift = 3'd1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL %s latency: got %0d want 3", name, lat);
    end
    checks++;
    if (out_data !== exp_d) begin
      errors++;
      $display("FAIL %s data: got %h want %h", name, out_data, exp_d);
    end
    checks++;
    if (out_err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b want %b", name, out_err, exp_err);
    end
`ifdef SHIFTER_STATUS_EN
    checks++;
    if (out_carry !== exp_c) begin
      errors++;
      $display("FAIL %s carry: got %b want %b", name, out_carry, exp_c);
    end
    checks++;
    if (out_zero !== (exp_d == 8'h00)) begin
      errors++;
      $display("FAIL %s zero: got %b want %b", name, out_zero, exp_d == 8'h00);
    end
`else
    if (exp_c === 1'bx) $display("note: %s has no carry expectation", name);
`endif
  endtask

  // Streams ops[0..n-1]; out_ready is held low for the first `stall` cycles.
  task automatic run_stream(input string name, input int n, input int stall);
    int         sent, rcv, first_out, gaps, rdy_drop;
    logic [7:0] held;
    logic       held_v;
    sent = 0; rcv = 0; first_out = -1; gaps = 0; rdy_drop = 0; held = '0; held_v = 1'b0;
    for (int cyc = 0; cyc < 200 && rcv < n; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      if (sent < n) begin
        in_valid = 1'b1;
        in_data  = ops[sent].d;
        in_shift = ops[sent].s;
        in_dir   = ops[sent].dir;
        in_mode  = ops[sent].mode;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1) begin
        if (first_out < 0) first_out = cyc;
        if (!out_ready) begin
          if (held_v) begin
            checks++;
            if (out_data !== held) begin
              errors++;
              $display("FAIL %s stall_stable: got %h want %h", name, out_data, held);
            end
          end
          held   = out_data;
          held_v = 1'b1;
        end else begin
          checks++;
          if (out_data !== ops[rcv].exp_d || out_err !== ops[rcv].exp_err) begin
            errors++;
            $display("FAIL %s result[%0d]: got %h/%b want %h/%b", name, rcv, out_data, out_err,
                     ops[rcv].exp_d, ops[rcv].exp_err);
          end
`ifdef SHIFTER_STATUS_EN
          checks++;
          if (out_carry !== ops[rcv].exp_c) begin
            errors++;
            $display("FAIL %s carry[%0d]: got %b want %b", name, rcv, out_carry, ops[rcv].exp_c);
          end
`endif
          rcv++;
        end
      end else if (first_out >= 0 && stall == 0) begin
        gaps++;
      end
      if (in_valid && in_ready) sent++;
      else if (in_valid && stall == 0) rdy_drop++;
      if (stall > 0 && cyc == stall - 1) begin
        checks++;
        if (sent != 3) begin
          errors++;
          $display("FAIL %s accepts_when_full: got %0d want 3", name, sent);
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s in_ready_full: got %b want 0", name, in_ready);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcv != n) begin
      errors++;
      $display("FAIL %s result_count: got %0d want %0d", name, rcv, n);
    end
    if (stall == 0) begin
      checks++;
      if (first_out != 3) begin
        errors++;
        $display("FAIL %s fill_latency: got %0d want 3", name, first_out);
      end
      checks++;
      if (gaps != 0 || rdy_drop != 0) begin
        errors++;
        $display("FAIL %s full_rate: got gaps=%0d stalls=%0d want 0/0", name, gaps, rdy_drop);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h e=%b want 0/00/0", out_valid, out_data, out_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_left_logical();
    run_op("ll3", 8'hD6, 3'd3, 1'b0, 2'd0, 8'hB0, 1'b0, 1'b0);
    run_op("la1", 8'hD6, 3'd1, 1'b0, 2'd1, 8'hAC, 1'b0, 1'b1);
  endtask

  task automatic test_right_shifts();
    run_op("ra2", 8'hD6, 3'd2, 1'b1, 2'd1, 8'hF5, 1'b0, 1'b1);
    run_op("rl7", 8'hD6, 3'd7, 1'b1, 2'd0, 8'h01, 1'b0, 1'b1);
    run_op("rl2", 8'hD6, 3'd2, 1'b1, 2'd0, 8'h35, 1'b0, 1'b1);
    run_op("ra7", 8'hD6, 3'd7, 1'b1, 2'd1, 8'hFF, 1'b0, 1'b1);
    run_op("ra4_pos", 8'h56, 3'd4, 1'b1, 2'd1, 8'h05, 1'b0, 1'b0);
  endtask

  task automatic test_rotate_and_reserved();
    run_op("lr5", 8'hD6, 3'd5, 1'b0, 2'd2, 8'hDA, 1'b0, 1'b0);
    run_op("rr0", 8'hD6, 3'd0, 1'b1, 2'd2, 8'hD6, 1'b0, 1'b0);
    run_op("rr3", 8'hD6, 3'd3, 1'b1, 2'd2, 8'hDA, 1'b0, 1'b1);
    run_op("rsv", 8'hD6, 3'd3, 1'b1, 2'd3, 8'h00, 1'b1, 1'b0);
    run_op("ll0", 8'hD6, 3'd0, 1'b0, 2'd0, 8'hD6, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    ops[0] = '{8'hD6, 3'd3, 1'b0, 2'd0, 8'hB0, 1'b0, 1'b0};
    ops[1] = '{8'hD6, 3'd2, 1'b1, 2'd1, 8'hF5, 1'b0, 1'b1};
    ops[2] = '{8'hD6, 3'd7, 1'b1, 2'd0, 8'h01, 1'b0, 1'b1};
    ops[3] = '{8'hD6, 3'd5, 1'b0, 2'd2, 8'hDA, 1'b0, 1'b0};
    ops[4] = '{8'hD6, 3'd2, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0};
    ops[5] = '{8'hD6, 3'd1, 1'b0, 2'd1, 8'hAC, 1'b0, 1'b1};
    run_stream("backpressure", 6, 6);
  endtask

  task automatic test_full_rate();
    for (int i = 0; i < 16; i++) begin
      logic [8:0] m;
      ops[i].d       = 8'hD6;
      ops[i].s       = 3'((i * 3) % 8);
      ops[i].dir     = ((i / 4) % 2) == 1;
      ops[i].mode    = 2'(i % 4);
      m              = model(ops[i].d, int'(ops[i].s), ops[i].dir, ops[i].mode);
      ops[i].exp_d   = m[7:0];
      ops[i].exp_c   = m[8];
      ops[i].exp_err = (ops[i].mode == 2'd3);
    end
    run_stream("full_rate", 16, 0);
  endtask

  task automatic test_reset_midstream();
    int wait_cyc;
    int stale;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hD6; in_shift = 3'd3; in_dir = 1'b0; in_mode = 2'd0;
    @(negedge clk);
    in_data   = 8'hD6; in_shift = 3'd2; in_dir = 1'b1; in_mode = 2'd1;
    @(negedge clk);
    in_valid  = 1'b0;
    wait_cyc  = 0;
    while (out_valid !== 1'b1 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB0) begin
      errors++;
      $display("FAIL pre_reset_head: got v=%b d=%h want 1/b0", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%h e=%b want 0/00/0", out_valid, out_data, out_err);
    end
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL stale_after_reset: got %0d valid cycles want 0", stale);
    end
    run_op("post_reset", 8'hD6, 3'd5, 1'b0, 2'd2, 8'hDA, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_left_logical();
    test_right_shifts();
    test_rotate_and_reserved();
    test_backpressure();
    test_full_rate();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter. It supports logical, arithmetic and rotate modes in both directions.
- One log-shifter stage per shift-amount bit; each stage is registered.
- Handshake is valid/ready on both input and output.
- Sits in the datapath between an operand source and the ALU writeback path, and replaces the fixed 4-bit registered shifter.

Parameters:
- WIDTH, 32, data width; power of two, >= 4.
- SHW, $clog2(WIDTH), derived; shift-amount width and pipeline depth (number of stages).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  shifter can accept an operation this cycle
- in_data  in  WIDTH  operand
- in_shift  in  SHW  shift amount, 0..WIDTH-1
- in_dir  in  1  0 = left, 1 = right
- in_mode  in  2  0 logical, 1 arithmetic, 2 rotate, 3 reserved
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- out_err  out  1  op used reserved mode

Behaviour:
- Reset: clk single clock; rst_n asynchronous, active-low. All stage valids = 0; out_valid = 0, out_data = 0, out_err = 0 (plus out_zero = 0, out_carry = 0 when the status feature is built). in_ready = 1 as soon as reset deasserts.
- Transfer rules:
  - Input handshake occurs when in_valid && in_ready.
  - Output handshake occurs when out_valid && out_ready.
- Pipeline:
  - Stage k (k = 0..SHW-1) shifts by 2^k when the carried shift[k] = 1; otherwise it passes data unchanged.
  - Each stage registers data, remaining control (shift, dir, mode) and valid.
  - Latency: SHW cycles from input handshake to out_valid, with out_ready held high.
- Flow control: per-stage bubble-collapsing.
  - stage_ready[k] = !valid[k] || stage_ready[k+1].
  - The last stage's stage_ready = !out_valid || out_ready.
  - in_ready = stage_ready[0].
  - Throughput: 1 op/cycle when not stalled.
  - Capacity: SHW ops in flight; all data is held stable while stalled.
- Ordering: results emerge in acceptance order. No drops, no duplicates.
- Output: out_data and out_valid stay stable while out_valid && !out_ready. Simultaneous output drain and input accept in the same cycle is legal when full.
- Arithmetic / width rules:
  - Left, logical or arithmetic: zero fill from LSB.
  - Right logical: zero fill from MSB.
  - Right arithmetic: fill with the original in_data[WIDTH-1]. The sign bit is captured at input and carried through the stages.
  - Rotate: bits wrap modulo WIDTH in the given direction.
  - shift = 0: out_data = in_data for every non-reserved mode.
- Reserved mode (3): out_data = 0 and out_err = 1; the op still occupies its pipeline slot and follows normal latency and ordering.
- Reset mid-operation: all in-flight ops are discarded and outputs return to their reset values. No result from before reset appears afterwards.
- Protocol obligations:
  - Source: in_* fields are sampled only on the input handshake; no stability is required otherwise.
  - Consumer: may hold out_ready low indefinitely.

Optional Feature:
- Macro: SHIFTER_STATUS_EN.
- When defined, adds two outputs, each 1 bit and registered alongside out_data:
  - out_zero: 1 when out_data == 0.
  - out_carry: the last bit shifted out, carried through the pipeline.
    - Left shift: in_data[WIDTH-shift].
    - Right logical/arithmetic: in_data[shift-1].
    - Rotate: result bit that last wrapped; left = out_data[0], right = out_data[WIDTH-1].
    - shift = 0 or reserved mode: 0.
- When not defined: ports absent, no extra registers.

Decomposition:
- Package shifter_pkg holds:
  - Mode constants MODE_LOG = 2'd0, MODE_ARI = 2'd1, MODE_ROT = 2'd2, MODE_RSV = 2'd3.
  - Direction constants DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
  - Stage control typedef: shift, dir, mode, sign, err, carry.
- Sub-module shifter_stage:
  - Parameters WIDTH and STAGE.
  - Performs a conditional 2^STAGE shift/rotate plus the valid/ready register slot.
  - Top level generates SHW instances.

Test Plan:
All scenarios use WIDTH = 8, SHW = 3, in_data = 8'hD6 (1101_0110).
1. Left logical, shift 3, out_ready = 1 -> out_data = 8'hB0 exactly 3 cycles after accept; out_err = 0; with the status feature, out_carry = 0.
2. Right arithmetic shift 2 -> 8'hF5. Right logical shift 7 -> 8'h01. Right logical shift 2 with the status feature -> out_carry = 1.
3. Left rotate shift 5 -> 8'hDA. Right rotate shift 0 -> 8'hD6. Mode 3 -> out_data = 8'h00, out_err = 1.
4. Backpressure: stream 6 ops back-to-back with out_ready = 0 for 6 cycles -> in_ready falls after 3 accepts. Releasing out_ready delivers all 6 results in order with correct values; out_data is stable while stalled.
5. Full-rate drain: out_ready = 1 and continuous in_valid for 16 ops -> in_ready stays 1, one result per cycle after a 3-cycle fill, and results match a reference model.
6. Reset mid-stream: assert rst_n = 0 with 2 ops in flight -> out_valid = 0 and out_data = 0 immediately (asynchronous). After release, no stale results appear; a new op completes with normal latency.
